ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters: none; widths fixed at 8-bit address, 8-bit data (256-byte data RAM).
REQ-002 clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU port access request, held until cpu_ack.
REQ-005 cpu_we  input  1  CPU port: 1 = write, 0 = read.
REQ-006 cpu_addr  input  8  CPU port byte address.
REQ-007 cpu_wdata  input  8  CPU port write data.
REQ-008 cpu_ack  output  1  one-cycle completion pulse to CPU port.
REQ-009 cpu_rdata  output  8  CPU port read data, valid with cpu_ack, held until next CPU read ack.
REQ-010 dbg_req, dbg_we, dbg_addr[8], dbg_wdata[8]  input  debug/loader port, same meaning as the CPU equivalents.
REQ-011 dbg_ack  output  1; dbg_rdata  output  8: debug port equivalents of cpu_ack, cpu_rdata.
REQ-012 ram_we  output  1  write strobe to the data RAM.
REQ-013 ram_addr  output  8; ram_wdata  output  8: RAM address and write data.
REQ-014 ram_rdata  input  8  RAM synchronous read output (valid the cycle after a read edge).
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, CAPTURE, ACK; transitions IDLE->ISSUE (any req), ISSUE->CAPTURE, CAPTURE->ACK, ACK->IDLE, unconditional except IDLE.
REQ-017 In IDLE with a request, the arbiter registers owner, we, addr, wdata of the winning port at the same edge it enters ISSUE.
REQ-018 ram_addr and ram_wdata are driven from the latched values in ISSUE and CAPTURE; 0x00 otherwise.
REQ-019 ram_we = (state==ISSUE) AND latched_we AND NOT reset; low in every other state.
REQ-020 At the CAPTURE->ACK edge, for a read, ram_rdata is loaded into the owner's rdata register; the non-owner's rdata is unchanged.
REQ-021 In ACK, only the owner's ack is 1, for exactly one cycle; fixed latency: ack in cycle 3 when req is first sampled in IDLE at cycle 0, for both reads and writes.
REQ-022 Writes do not modify any rdata register.
REQ-023 Requests arriving in ISSUE/CAPTURE/ACK are not sampled; the losing requester waits, its req held, and is arbitrated in the next IDLE.
REQ-024 A req still high in the IDLE following its ack is a new transaction.
REQ-025 Request inputs changing while not in IDLE have no effect on the transaction in flight.
REQ-026 Simultaneous requests in IDLE resolve per REQ-031/REQ-032; exactly one port is granted.
REQ-027 Address 0xFF and 0x00 are ordinary addresses; no wrap or range logic.

Reset
REQ-028 On reset: state IDLE; cpu_ack, dbg_ack, ram_we, busy = 0; cpu_rdata, dbg_rdata, ram_addr, ram_wdata = 0x00; last_owner = DBG.
REQ-029 Reset in any state aborts the transaction with no ack; reset high during ISSUE suppresses the RAM write.
REQ-030 RAM contents are not cleared by this block.

Configuration
REQ-031 Macro RAM_ARB_RR_EN defined: round-robin; on simultaneous requests the port not equal to last_owner wins; last_owner updates on every grant.
REQ-032 RAM_ARB_RR_EN undefined: fixed priority, CPU always wins simultaneous requests; last_owner logic removed.

Verification
REQ-033 CPU write 0x5A to 0x10, then CPU read 0x10 -> ram_we high only in ISSUE cycle; cpu_ack cycle 3 each; cpu_rdata=0x5A.
REQ-034 DBG write 0xC3 to 0xFF, CPU read 0xFF -> cpu_rdata=0xC3; dbg_rdata stays 0x00.
REQ-035 Both req high continuously from reset, RR_EN defined -> grants alternate CPU, DBG, CPU, DBG; each ack 4 cycles apart.
REQ-036 Same stimulus, RR_EN undefined -> CPU granted every transaction, dbg_ack never asserts while cpu_req held.
REQ-037 CPU write 0x77 to 0x20 with reset asserted in ISSUE cycle, then read 0x20 -> prior value returned, no cpu_ack for aborted write.
REQ-038 CPU req drops/changes addr during CAPTURE -> transaction completes with originally latched addr, ack still issued.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates CPU and debug ports onto one synchronous 256x8 data RAM with a fixed 4-cycle transaction.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise the CPU port wins simultaneous requests.
module ram_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [7:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_ack,
    output logic [7:0] dbg_rdata,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;
    state_t state, state_nx;
    logic owner;
    logic grant_dbg;
    logic start;
    logic lat_we;
    logic [7:0] lat_addr, lat_wdata;
    assign start = state == IDLE && (cpu_req || dbg_req);
`ifdef RAM_ARB_RR_EN
    logic last_owner;
    always_ff @(posedge clk)
        if (reset) last_owner <= 1'b1;
        else if (start) last_owner <= grant_dbg;
    // on a tie, the port that did not win last time goes first
    assign grant_dbg = dbg_req && (!cpu_req || !last_owner);
`else
    assign grant_dbg = dbg_req && !cpu_req;
`endif
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ISSUE : IDLE;
            ISSUE:   state_nx = CAPTURE;
            CAPTURE: state_nx = ACK;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        busy      = state != IDLE;
        ram_we    = state == ISSUE && lat_we && !reset;
        ram_addr  = (state == ISSUE || state == CAPTURE) ? lat_addr : 8'h00;
        ram_wdata = (state == ISSUE || state == CAPTURE) ? lat_wdata : 8'h00;
        cpu_ack   = state == ACK && !owner;
        dbg_ack   = state == ACK && owner;
    end
    always_ff @(posedge clk)
        if (reset) begin
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 8'h00;
            lat_wdata <= 8'h00;
            cpu_rdata <= 8'h00;
            dbg_rdata <= 8'h00;
        end else begin
            if (start) begin
                owner     <= grant_dbg;
                lat_we    <= grant_dbg ? dbg_we : cpu_we;
                lat_addr  <= grant_dbg ? dbg_addr : cpu_addr;
                lat_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            end
            // RAM read data is valid during CAPTURE, one cycle after the read edge
            if (state == CAPTURE && !lat_we) begin
                if (owner) dbg_rdata <= ram_rdata;
                else cpu_rdata <= ram_rdata;
            end
        end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized bench for ram_arbiter against a transaction-level model with its own memory image.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
    logic dbg_req = 1'b0, dbg_we = 1'b0;
    logic [7:0] dbg_addr = 8'h00, dbg_wdata = 8'h00;
    logic cpu_ack, dbg_ack, ram_we, busy;
    logic [7:0] cpu_rdata, dbg_rdata, ram_addr, ram_wdata, ram_rdata;
    ram_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy)
    );
    always #5 clk = ~clk;
    logic [7:0] mem [256] = '{default: 8'h00};
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef struct {
        bit         we;
        logic [7:0] a;
        logic [7:0] d;
    } txn_t;
    txn_t cq[$], dq[$];
    int ack_log[$];
    logic [7:0] mem_m [256] = '{default: 8'h00};
    int vecs = 0, errs = 0;
    int c = 0, t0 = 0, free_at = 0;
    bit act = 0, g_own = 0, g_we = 0, last = 1;
    logic [7:0] g_addr, g_wdata, g_rd;
    logic [7:0] exp_crd = 8'h00, exp_drd = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic txn_t mk(input bit we, input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        t.we = we;
        t.a = a;
        t.d = d;
        return t;
    endfunction

    // drive both ports, then decide a grant from the values the DUT samples at the next edge
    task automatic drive_grant();
        if (act && !g_own) begin
            if ($urandom_range(0, 1) == 1) {cpu_req, cpu_we, cpu_addr, cpu_wdata} = 18'($urandom);
        end else begin
            cpu_req = cq.size() > 0;
            if (cq.size() > 0) {cpu_we, cpu_addr, cpu_wdata} = {cq[0].we, cq[0].a, cq[0].d};
        end
        if (act && g_own) begin
            if ($urandom_range(0, 1) == 1) {dbg_req, dbg_we, dbg_addr, dbg_wdata} = 18'($urandom);
        end else begin
            dbg_req = dq.size() > 0;
            if (dq.size() > 0) {dbg_we, dbg_addr, dbg_wdata} = {dq[0].we, dq[0].a, dq[0].d};
        end
        if (!act && c >= free_at && (cpu_req || dbg_req)) begin
            g_own = (cpu_req && dbg_req) ? (RR ? !last : 1'b0) : dbg_req;
            last = g_own;
            g_we = g_own ? dbg_we : cpu_we;
            g_addr = g_own ? dbg_addr : cpu_addr;
            g_wdata = g_own ? dbg_wdata : cpu_wdata;
            g_rd = mem_m[g_addr];
            act = 1;
            t0 = c;
            free_at = c + 4;
        end
    endtask

    task automatic tick();
        bool_dummy: begin end
        @(negedge clk);
        c++;
        if (act && c == t0 + 3 && !g_we) begin
            if (g_own) exp_drd = g_rd;
            else exp_crd = g_rd;
        end
        chk("busy", busy, c < free_at);
        chk("ram_we", ram_we, act && g_we && c == t0 + 1);
        chk("ram_addr", ram_addr, (act && (c == t0 + 1 || c == t0 + 2)) ? g_addr : 8'h00);
        chk("ram_wdata", ram_wdata, (act && (c == t0 + 1 || c == t0 + 2)) ? g_wdata : 8'h00);
        chk("cpu_ack", cpu_ack, act && c == t0 + 3 && !g_own);
        chk("dbg_ack", dbg_ack, act && c == t0 + 3 && g_own);
        chk("cpu_rdata", cpu_rdata, exp_crd);
        chk("dbg_rdata", dbg_rdata, exp_drd);
        if (cpu_ack) ack_log.push_back(0);
        if (dbg_ack) ack_log.push_back(1);
        if (act && g_we && c == t0 + 1) mem_m[g_addr] = g_wdata;
        if (act && c == t0 + 3) begin
            act = 0;
            if (g_own) void'(dq.pop_front());
            else void'(cq.pop_front());
        end
        drive_grant();
    endtask

    // caller sits at a negedge; an in-flight transaction is dropped without ack
    task automatic apply_reset();
        reset = 1'b1;
        #1 chk("rst_ram_we", ram_we, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        if (act) begin
            if (g_own) void'(dq.pop_front());
            else void'(cq.pop_front());
        end
        act = 0;
        free_at = 0;
        last = 1;
        exp_crd = 8'h00;
        exp_drd = 8'h00;
        chk("rst_busy", busy, 1'b0);
        chk("rst_acks", {cpu_ack, dbg_ack}, 2'b00);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 16'h0000);
        chk("rst_ram_addr", {ram_addr, ram_wdata}, 16'h0000);
        drive_grant();
    endtask

    task automatic drain();
        int n = 0;
        while ((cq.size() > 0 || dq.size() > 0 || act) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 300, 1'b1);
    endtask

    function automatic txn_t rnd_txn();
        int r = $urandom_range(0, 5);
        logic [7:0] a = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom_range(0, 15));
        return mk(1'($urandom), a, 8'($urandom));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        apply_reset();
        cq.push_back(mk(1, 8'h10, 8'h5A));
        cq.push_back(mk(0, 8'h10, 8'h00));
        drain();
        chk("cpu_read_5a", cpu_rdata, 8'h5A);
        dq.push_back(mk(1, 8'hFF, 8'hC3));
        drain();
        cq.push_back(mk(0, 8'hFF, 8'h00));
        drain();
        chk("cpu_read_ff", cpu_rdata, 8'hC3);
        chk("dbg_rdata_idle", dbg_rdata, 8'h00);
        cq.push_back(mk(1, 8'h20, 8'h11));
        drain();
        cq.push_back(mk(1, 8'h20, 8'h77));
        for (int i = 0; i < 10 && !act; i++) tick();
        chk("abort_grant", act, 1'b1);
        @(negedge clk);
        chk("issue_we", ram_we, 1'b1);
        apply_reset();
        cq.push_back(mk(0, 8'h20, 8'h00));
        drain();
        chk("abort_keeps_old", cpu_rdata, 8'h11);
        for (int i = 0; i < 4; i++) begin
            cq.push_back(mk(0, 8'(8'h10 + i), 8'h00));
            dq.push_back(mk(0, 8'(8'hF0 + i), 8'h00));
        end
        ack_log.delete();
        apply_reset();
        drain();
        for (int i = 0; i < 4; i++)
            chk("arb_order", (ack_log.size() > i) ? ack_log[i] : 9, RR ? (i % 2) : 0);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0 && cq.size() < 3) cq.push_back(rnd_txn());
            if ($urandom_range(0, 3) == 0 && dq.size() < 3) dq.push_back(rnd_txn());
            tick();
        end
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
